// File: rtl/mfm_pkg.sv
// Shared types and interval thresholds for the MFM read-channel word decoder.
package mfm_pkg;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PREAMBLE = 2'd1,
    LOCKED   = 2'd2
  } stateT;

  typedef enum logic [1:0] {
    I2  = 2'd0,
    I3  = 2'd1,
    I4  = 2'd2,
    ERR = 2'd3
  } ivlClassT;

  typedef enum logic {
    PH_C = 1'b0,
    PH_D = 1'b1
  } phaseT;

  // Boundary between the k-cell and (k+1)-cell interval bins, in clk cycles.
  function automatic int thr(input int n, input int k);
    return ((32'sd2 * k + 32'sd1) * n) / 32'sd2;
  endfunction

endpackage

// File: rtl/mfm_interval_classifier.sv
// Edge-to-edge interval timer and classifier: reports the class of each completed
// interval and a single timeout pulse when no edge arrives within 4.5 cells.
module mfm_interval_classifier
  import mfm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clear,
  input  logic     strobe,
  output ivlClassT ivlClass,
  output logic     ivlValid,
  output logic     timeout
);

  localparam int TW = $clog2(5 * N);
  localparam logic [TW-1:0] T2 = TW'(thr(N, 1));
  localparam logic [TW-1:0] T3 = TW'(thr(N, 2));
  localparam logic [TW-1:0] T4 = TW'(thr(N, 3));
  localparam logic [TW-1:0] T5 = TW'(thr(N, 4));

  logic [TW-1:0] timer;
  logic          armed;

  // Bin the current interval length; timer equals the interval on the strobe cycle.
  always_comb begin
    ivlClass = ERR;
    if (timer < T2) begin
      ivlClass = ERR;
    end else if (timer < T3) begin
      ivlClass = I2;
    end else if (timer < T4) begin
      ivlClass = I3;
    end else if (timer < T5) begin
      ivlClass = I4;
    end else begin
      ivlClass = ERR;
    end
  end

  // A strobe only yields an interval once a previous strobe has started the timer.
  assign ivlValid = strobe & armed;
  assign timeout  = armed & ~strobe & (timer == T5);

  // Interval timer: restarts at 1 on each strobe, saturates at the timeout point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      timer <= '0;
      armed <= 1'b0;
    end else if (strobe) begin
      timer <= TW'(1);
      armed <= 1'b1;
    end else begin
      armed <= armed & ~timeout;
      if (timer < T5) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= timer;
      end
    end
  end

endmodule

// File: rtl/mfm_word_decoder.sv
// MFM read-channel decoder: hunts preamble, locks on the sync bit and assembles
// MSB-first words from classified flux-transition intervals.
module mfm_word_decoder
  import mfm_pkg::*;
#(
  parameter int CLKS_PER_CELL = 8,
  parameter int WORD_W        = 16,
  parameter int PREAMBLE_MIN  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mfmEdge,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              locked,
  output logic              sync_pulse,
  output logic              bit_error
);

  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  ivlClassT          ivlClass;
  logic              ivlValid;
  logic              timeout;

  stateT             state, stateNext;
  phaseT             phase, phaseNext;
  logic [PW-1:0]     preCnt, preCntNext;
  logic [WORD_W-1:0] shiftReg, shiftNext, wordNext;
  logic [BW-1:0]     bitCnt, bitCntNext;
  logic [1:0]        emitN;
  logic [1:0]        emitBits;
  logic              dropWord, syncNext, errNext, wordValidNext;

  mfm_interval_classifier #(.N(CLKS_PER_CELL)) classifier (
    .clk      (clk),
    .rst      (rst),
    .clear    (~enable),
    .strobe   (mfmEdge),
    .ivlClass (ivlClass),
    .ivlValid (ivlValid),
    .timeout  (timeout)
  );

  // Lock FSM and MFM bit recovery; emitBits[1] is the earlier bit.
  always_comb begin
    stateNext  = state;
    phaseNext  = phase;
    preCntNext = preCnt;
    emitN      = 2'd0;
    emitBits   = 2'b00;
    dropWord   = 1'b0;
    syncNext   = 1'b0;
    errNext    = 1'b0;
    if (!enable) begin
      stateNext = HUNT;
      dropWord  = 1'b1;
    end else begin
      case (state)
        HUNT: begin
          if (ivlValid && ivlClass == I2) begin
            stateNext  = PREAMBLE;
            preCntNext = PW'(1);
          end else begin
            stateNext = HUNT;
          end
        end
        PREAMBLE: begin
          if (ivlValid) begin
            if (ivlClass == I2) begin
              preCntNext = (preCnt < PW'(PREAMBLE_MIN)) ? preCnt + PW'(1) : preCnt;
            end else if (ivlClass == I3 && preCnt >= PW'(PREAMBLE_MIN)) begin
              stateNext = LOCKED;
              phaseNext = PH_D;
              syncNext  = 1'b1;
              dropWord  = 1'b1;
            end else begin
              stateNext = HUNT;
            end
          end else if (timeout) begin
            stateNext = HUNT;
          end else begin
            stateNext = PREAMBLE;
          end
        end
        LOCKED: begin
          if (ivlValid) begin
            case (phase)
              PH_C: begin
                case (ivlClass)
                  I2: begin emitN = 2'd1; emitBits = 2'b00; end
                  I3: begin emitN = 2'd1; emitBits = 2'b10; phaseNext = PH_D; end
                  default: begin stateNext = HUNT; errNext = 1'b1; dropWord = 1'b1; end
                endcase
              end
              PH_D: begin
                case (ivlClass)
                  I2: begin emitN = 2'd1; emitBits = 2'b10; end
                  I3: begin emitN = 2'd2; emitBits = 2'b00; phaseNext = PH_C; end
                  I4: begin emitN = 2'd2; emitBits = 2'b01; end
                  default: begin stateNext = HUNT; errNext = 1'b1; dropWord = 1'b1; end
                endcase
              end
              default: begin stateNext = HUNT; errNext = 1'b1; dropWord = 1'b1; end
            endcase
          end else if (timeout) begin
            stateNext = HUNT;
            errNext   = 1'b1;
            dropWord  = 1'b1;
          end else begin
            stateNext = LOCKED;
          end
        end
        default: begin
          stateNext = HUNT;
          dropWord  = 1'b1;
        end
      endcase
    end
  end

  // Shift in up to two bits; a word may complete on the first, the second then starts the next.
  always_comb begin
    shiftNext     = shiftReg;
    bitCntNext    = bitCnt;
    wordNext      = word;
    wordValidNext = 1'b0;
    if (dropWord) begin
      bitCntNext = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (i < int'(emitN)) begin
          shiftNext  = {shiftNext[WORD_W-2:0], emitBits[1-i]};
          bitCntNext = bitCntNext + BW'(1);
          if (bitCntNext == BW'(WORD_W)) begin
            wordNext      = shiftNext;
            wordValidNext = 1'b1;
            bitCntNext    = '0;
          end else begin
            wordNext = wordNext;
          end
        end else begin
          shiftNext = shiftNext;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= HUNT;
      phase      <= PH_C;
      preCnt     <= '0;
      shiftReg   <= '0;
      bitCnt     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      sync_pulse <= 1'b0;
      bit_error  <= 1'b0;
    end else begin
      state      <= stateNext;
      phase      <= phaseNext;
      preCnt     <= preCntNext;
      shiftReg   <= shiftNext;
      bitCnt     <= bitCntNext;
      word       <= wordNext;
      word_valid <= wordValidNext;
      locked     <= (stateNext == LOCKED);
      sync_pulse <= syncNext;
      bit_error  <= errNext;
    end
  end

endmodule
